// File: rtl/lsu_pkg.sv
// Shared LSU definitions: size codes, FSM states, lane widths.
// Imported by the lane unit and the memory adapter.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int LANE_B = 8;
  localparam int LANE_H = 16;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE_WR,
    RESP
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (sz == SZ_BYTE): m = 1'b0;
      (sz == SZ_HALF): m = off[0];
      (sz == SZ_WORD): m = (off != 2'b00);
      default:         m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_adapter_lane.sv
// Lane extract/extend for loads and lane merge for stores.
// Purely combinational; offset picks the little-endian lane.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [31:0] w_bsel;
  logic [31:0] w_hsel;
  logic [31:0] w_bmask;
  logic [31:0] w_hmask;
  logic [31:0] w_bput;
  logic [31:0] w_hput;

  assign w_bsh   = {i_off, 3'b000};
  assign w_hsh   = {i_off[1], 4'b0000};
  assign w_bsel  = i_word >> w_bsh;
  assign w_hsel  = i_word >> w_hsh;
  assign w_bmask = 32'h0000_00FF << w_bsh;
  assign w_hmask = 32'h0000_FFFF << w_hsh;
  assign w_bput  = {24'b0, i_wdata[LANE_B-1:0]} << w_bsh;
  assign w_hput  = {16'b0, i_wdata[LANE_H-1:0]} << w_hsh;

  // Load path: select lane, then sign or zero extend.
  always_comb begin
    o_load = i_word;
    unique case (1'b1)
      (i_size == SZ_BYTE):
        o_load = {{24{i_signed & w_bsel[7]}},
                  w_bsel[7:0]};
      (i_size == SZ_HALF):
        o_load = {{16{i_signed & w_hsel[15]}},
                  w_hsel[15:0]};
      default:
        o_load = i_word;
    endcase
  end

  // Store path: replace one lane of the old word.
  always_comb begin
    o_merge = i_wdata;
    unique case (1'b1)
      (i_size == SZ_BYTE):
        o_merge = (i_word & ~w_bmask) | w_bput;
      (i_size == SZ_HALF):
        o_merge = (i_word & ~w_hmask) | w_hput;
      default:
        o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// LSU to word-only memory adapter with sub-word RMW stores.
// LSU_MISALIGN_TRAP_EN: flag misaligned/illegal, else force-align.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic              r_signed;
  logic              r_mis;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_merge;

  logic              w_acc;
  logic              w_mis;
  logic              w_sub;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;

  assign w_acc   = req_valid && (r_state == IDLE);
  assign w_sub   = (r_size == SZ_BYTE) ||
                   (r_size == SZ_HALF);
  assign w_waddr = {r_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_size = req_size;
  assign w_mis  = misaligned(req_size, req_addr[1:0]);
`else
  assign w_size = (req_size == SZ_ILL) ? SZ_WORD
                                       : req_size;
  assign w_mis  = 1'b0;
`endif

  lsu_lane_unit u_lane (
    .i_size   (r_size),
    .i_off    (r_addr[1:0]),
    .i_signed (r_signed),
    .i_word   (mem_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // State register; reset aborts any access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and memory strobes from state + latched request.
  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) w_next = w_mis ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = w_waddr;
        if (!r_we) begin
          mem_read = 1'b1;
          w_next   = RESP;
        end else if (w_sub) begin
          mem_read = 1'b1;
          w_next   = MERGE_WR;
        end else begin
          mem_write = 1'b1;
          mem_wdata = r_wdata;
          w_next    = RESP;
        end
      end
      MERGE_WR: begin
        mem_addr  = w_waddr;
        mem_write = 1'b1;
        mem_wdata = r_merge;
        w_next    = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, load result and merge word capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_mis    <= 1'b0;
      r_size   <= SZ_BYTE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merge  <= '0;
    end else begin
      if (w_acc) begin
        r_we     <= req_we;
        r_signed <= req_signed;
        r_mis    <= w_mis;
        r_size   <= w_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
      end
      if (r_state == ACCESS && !r_we)
        r_rdata <= w_load;
      if (r_state == ACCESS && r_we && w_sub)
        r_merge <= w_merge;
    end
  end

  assign req_ready     = (r_state == IDLE);
  assign resp_valid    = (r_state == RESP);
  assign resp_rdata    = resp_valid ? r_rdata : '0;
  assign resp_misalign = resp_valid & r_mis;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a word memory model.
// Expected responses are queued at issue and popped on resp.
module tb_lsu_mem_adapter;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:15];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          rd_k;
    int          wr_k;
    logic [31:0] wd;
  } exp_t;

  exp_t sbq[$];

  lsu_mem_adapter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk)
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= '0;
    mem[0] <= 32'h0000_0132;
    mem[1] <= 32'h0000_0148;
    mem[2] <= 32'h0000_02E2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd,
                              input logic mis,
                              input int lat,
                              input int rk,
                              input int wk,
                              input logic [31:0] wd);
    exp_t e;
    e.rdata = rd;
    e.mis   = mis;
    e.lat   = lat;
    e.rd_k  = rk;
    e.wr_k  = wk;
    e.wd    = wd;
    return e;
  endfunction

  task automatic req(input string tag,
                     input logic we,
                     input logic [1:0] sz,
                     input logic sg,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input exp_t e);
    exp_t x;
    int rk, wk, lat;
    logic got, both, mis_s;
    logic [31:0] wd_s, rd_s;
    @(negedge clk);
    chk({tag, ".ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
    rk = 0; wk = 0; lat = 0;
    got = 1'b0; both = 1'b0; mis_s = 1'b0;
    wd_s = '0; rd_s = '0;
    for (int k = 1; k <= 8; k++) begin
      if (!got) begin
        if (k > 1) @(negedge clk);
        if (mem_read && mem_write) both = 1'b1;
        if (mem_read && rk == 0) rk = k;
        if (mem_write && wk == 0) begin
          wk   = k;
          wd_s = mem_wdata;
        end
        if (resp_valid) begin
          got   = 1'b1;
          lat   = k;
          rd_s  = resp_rdata;
          mis_s = resp_misalign;
        end
      end
    end
    chk({tag, ".resp_seen"}, {31'b0, got}, 32'd1);
    x = sbq.pop_front();
    chk({tag, ".latency"}, lat, x.lat);
    chk({tag, ".rdata"}, rd_s, x.rdata);
    chk({tag, ".misalign"}, {31'b0, mis_s}, {31'b0, x.mis});
    chk({tag, ".read_cyc"}, rk, x.rd_k);
    chk({tag, ".write_cyc"}, wk, x.wr_k);
    chk({tag, ".wdata"}, wd_s, x.wd);
    chk({tag, ".excl_en"}, {31'b0, both}, 32'd0);
    @(negedge clk);
    chk({tag, ".one_pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'b0, req_ready}, 32'd1);
    chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.misalign", {31'b0, resp_misalign}, 32'd0);
    chk("rst.mem_en", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    req("lw0", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0,
        mk(32'h0000_0132, 1'b0, 2, 1, 0, 32'h0));
    req("sb5", 1'b1, SZ_BYTE, 1'b0, 32'h5, 32'h0000_00AB,
        mk(32'h0, 1'b0, 3, 1, 2, 32'h0000_AB48));
    req("lw4", 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0,
        mk(32'h0000_AB48, 1'b0, 2, 1, 0, 32'h0));
    req("lb5", 1'b0, SZ_BYTE, 1'b1, 32'h5, 32'h0,
        mk(32'hFFFF_FFAB, 1'b0, 2, 1, 0, 32'h0));
    req("lbu5", 1'b0, SZ_BYTE, 1'b0, 32'h5, 32'h0,
        mk(32'h0000_00AB, 1'b0, 2, 1, 0, 32'h0));
    req("shA", 1'b1, SZ_HALF, 1'b0, 32'hA, 32'h0000_BEEF,
        mk(32'h0, 1'b0, 3, 1, 2, 32'hBEEF_02E2));
    chk("word2", mem[2], 32'hBEEF_02E2);
    req("lhA", 1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0,
        mk(32'hFFFF_BEEF, 1'b0, 2, 1, 0, 32'h0));
    req("lhuA", 1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0,
        mk(32'h0000_BEEF, 1'b0, 2, 1, 0, 32'h0));
    req("lbB", 1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0,
        mk(32'hFFFF_FFBE, 1'b0, 2, 1, 0, 32'h0));
    req("lbu8", 1'b0, SZ_BYTE, 1'b0, 32'h8, 32'h0,
        mk(32'h0000_00E2, 1'b0, 2, 1, 0, 32'h0));
    req("swC", 1'b1, SZ_WORD, 1'b0, 32'hC, 32'h1234_5678,
        mk(32'h0, 1'b0, 2, 0, 1, 32'h1234_5678));
    req("lhuC", 1'b0, SZ_HALF, 1'b0, 32'hC, 32'h0,
        mk(32'h0000_5678, 1'b0, 2, 1, 0, 32'h0));
    req("lhE", 1'b0, SZ_HALF, 1'b1, 32'hE, 32'h0,
        mk(32'h0000_1234, 1'b0, 2, 1, 0, 32'h0));
    req("lbuF", 1'b0, SZ_BYTE, 1'b0, 32'hF, 32'h0,
        mk(32'h0000_0012, 1'b0, 2, 1, 0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    req("lw6", 1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0,
        mk(32'h0, 1'b1, 1, 0, 0, 32'h0));
`else
    req("lw6", 1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0,
        mk(32'h0000_AB48, 1'b0, 2, 1, 0, 32'h0));
`endif

    // Abort a sub-word store while it is in MERGE_WR.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.read", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    chk("abort.merge_wr", {31'b0, mem_write}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort.wr_drop", {31'b0, mem_write}, 32'd0);
    chk("abort.ready", {31'b0, req_ready}, 32'd1);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("abort.no_resp", pulses, 32'd0);
    chk("abort.word0", mem[0], 32'h0000_0132);
    chk("abort.ready_after", {31'b0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
